// File: rtl/interp_pkg.sv
// Shared widths, reciprocal table and saturation limits for the multi-channel interpolator.
package interp_pkg;

  localparam int NCH_DEF      = 3;
  localparam int PIX_W_DEF    = 10;
  localparam int LVL_W_DEF    = 8;
  localparam int BND_W_DEF    = 12;
  localparam int MAX_INTV_DEF = 16;
  localparam int CNT_W_DEF    = 16;

  localparam int RECIP_FRAC = 16;
  localparam int RECIP_W    = 17;

  localparam int BND_SAT = (1 << BND_W_DEF) - 1;

  // floor(2^RECIP_FRAC / n); entry 0 is never selected after clamping and reads as 0.
  function automatic logic [RECIP_W-1:0] RECIP_LUT(input int n);
    if (n < 1) begin
      return '0;
    end
    return RECIP_W'((1 << RECIP_FRAC) / n);
  endfunction

endpackage

// File: rtl/interp_lane.sv
// One channel of the interpolator: clamp/diff (S1), multiply + reciprocal lookup (S2),
// scale/offset/saturate (S3). Build with INTERP_ROUND_EN for round-half-up in S3.
module interp_lane
  import interp_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int LVL_W    = LVL_W_DEF,
  parameter int BND_W    = BND_W_DEF,
  parameter int MAX_INTV = MAX_INTV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] pixel,
  input  logic [LVL_W-1:0] low_level,
  input  logic [LVL_W:0]   high_level,
  input  logic [BND_W-1:0] lobound,
  input  logic [BND_W-1:0] upbound,
  output logic [BND_W-1:0] bound,
  output logic             clamp
);

  localparam int IV_W  = $clog2(MAX_INTV + 1);
  localparam int IS_W  = LVL_W + 2;
  localparam int LV4_W = LVL_W + 2;
  localparam int AS_W  = ((PIX_W > LV4_W) ? PIX_W : LV4_W) + 1;
  localparam int DL_W  = BND_W + PIX_W;
  localparam int PR_W  = DL_W + RECIP_W;
  localparam int SH    = RECIP_FRAC + 2;
  localparam int Q_W   = PR_W - SH;
  localparam logic [Q_W:0] SAT = (Q_W + 1)'((1 << BND_W) - 1);
`ifdef INTERP_ROUND_EN
  localparam logic [PR_W-1:0] RND = PR_W'(1) << (RECIP_FRAC + 1);
`else
  localparam logic [PR_W-1:0] RND = '0;
`endif

  logic signed [BND_W:0]  diff_s;
  logic signed [IS_W-1:0] intv_s;
  logic signed [AS_W-1:0] alpha_s;
  logic [BND_W-1:0]       diff_c;
  logic [IV_W-1:0]        intv_c;
  logic [IV_W+1:0]        amax;
  logic [PIX_W-1:0]       alpha_c;
  logic                   clamp_c;

  logic [BND_W-1:0]       diff_reg, lob1_reg, lob2_reg, bound_reg;
  logic [PIX_W-1:0]       alpha_reg;
  logic [IV_W-1:0]        intv_reg;
  logic                   clamp_reg;
  logic [DL_W-1:0]        delta_reg;
  logic [RECIP_W-1:0]     recip_reg;

  logic [PR_W-1:0]        prod;
  logic [Q_W-1:0]         q;
  logic [Q_W:0]           sum;
  logic [BND_W-1:0]       bound_next;

  logic [RECIP_W-1:0]     recip_rom [2**IV_W];

  for (genvar gi = 0; gi < 2**IV_W; gi++) begin : g_recip
    assign recip_rom[gi] = RECIP_LUT(gi);
  end

  always_comb begin
    diff_s  = $signed({1'b0, upbound}) - $signed({1'b0, lobound});
    intv_s  = $signed({1'b0, high_level}) - $signed({2'b00, low_level});
    alpha_s = $signed(AS_W'(pixel)) - $signed(AS_W'({low_level, 2'b00}));
    clamp_c = 1'b0;

    diff_c = diff_s[BND_W-1:0];
    if (diff_s[BND_W]) begin
      diff_c  = '0;
      clamp_c = 1'b1;
    end

    intv_c = intv_s[IV_W-1:0];
    if (intv_s[IS_W-1] || (intv_s == '0)) begin
      intv_c  = IV_W'(1);
      clamp_c = 1'b1;
    end else if (intv_s > $signed(IS_W'(MAX_INTV))) begin
      intv_c  = IV_W'(MAX_INTV);
      clamp_c = 1'b1;
    end

    // alpha is bounded by the clamped interval expressed in quarter-level units
    amax    = {intv_c, 2'b00};
    alpha_c = alpha_s[PIX_W-1:0];
    if (alpha_s[AS_W-1]) begin
      alpha_c = '0;
      clamp_c = 1'b1;
    end else if (alpha_s > $signed(AS_W'(amax))) begin
      alpha_c = PIX_W'(amax);
      clamp_c = 1'b1;
    end
  end

  always_comb begin
    prod       = PR_W'(delta_reg) * PR_W'(recip_reg) + RND;
    q          = Q_W'(prod >> SH);
    sum        = (Q_W + 1)'(lob2_reg) + (Q_W + 1)'(q);
    bound_next = (sum > SAT) ? {BND_W{1'b1}} : sum[BND_W-1:0];
  end

  // Invalid cycles load zeros so blanking drains the pipe with zero data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_reg  <= '0;
      alpha_reg <= '0;
      intv_reg  <= '0;
      lob1_reg  <= '0;
      clamp_reg <= 1'b0;
      delta_reg <= '0;
      recip_reg <= '0;
      lob2_reg  <= '0;
      bound_reg <= '0;
    end else begin
      diff_reg  <= in_valid ? diff_c  : '0;
      alpha_reg <= in_valid ? alpha_c : '0;
      intv_reg  <= in_valid ? intv_c  : '0;
      lob1_reg  <= in_valid ? lobound : '0;
      clamp_reg <= in_valid & clamp_c;
      delta_reg <= DL_W'(diff_reg) * DL_W'(alpha_reg);
      recip_reg <= recip_rom[intv_reg];
      lob2_reg  <= lob1_reg;
      bound_reg <= bound_next;
    end
  end

  assign bound = bound_reg;
  assign clamp = clamp_reg;

endmodule

// File: rtl/interpolator_mc.sv
// Multi-channel bound interpolator: NCH lanes, 3-cycle sync/valid delay line and a
// per-frame clamp-event counter. Optional macro INTERP_ROUND_EN selects rounding in the lanes.
module interpolator_mc
  import interp_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int LVL_W    = LVL_W_DEF,
  parameter int BND_W    = BND_W_DEF,
  parameter int MAX_INTV = MAX_INTV_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_hs,
  input  logic                   i_vs,
  input  logic [NCH*PIX_W-1:0]   pixel_in,
  input  logic [NCH*LVL_W-1:0]   lowLevel,
  input  logic [NCH*(LVL_W+1)-1:0] highLevel,
  input  logic [NCH*BND_W-1:0]   lobound,
  input  logic [NCH*BND_W-1:0]   upbound,
  output logic                   o_hs,
  output logic                   o_vs,
  output logic                   o_valid,
  output logic [NCH*BND_W-1:0]   bound_out,
  output logic [CNT_W-1:0]       clamp_cnt
);

  localparam int PC_W = $clog2(NCH + 1);

  logic             in_valid;
  logic [2:0]       hs_dl_reg, vs_dl_reg, v_dl_reg;
  logic             vs_prev_reg;
  logic [NCH-1:0]   clamp_vec;
  logic [PC_W-1:0]  add;
  logic [CNT_W:0]   work_sum;
  logic [CNT_W-1:0] work_next, work_reg, clamp_cnt_reg;

  assign in_valid = i_hs & i_vs;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    interp_lane #(
      .PIX_W(PIX_W), .LVL_W(LVL_W), .BND_W(BND_W), .MAX_INTV(MAX_INTV)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .pixel     (pixel_in[gi*PIX_W +: PIX_W]),
      .low_level (lowLevel[gi*LVL_W +: LVL_W]),
      .high_level(highLevel[gi*(LVL_W+1) +: (LVL_W+1)]),
      .lobound   (lobound[gi*BND_W +: BND_W]),
      .upbound   (upbound[gi*BND_W +: BND_W]),
      .bound     (bound_out[gi*BND_W +: BND_W]),
      .clamp     (clamp_vec[gi])
    );
  end

  // Lane flags are already gated by input valid, so a plain popcount is the event count.
  always_comb begin
    add = '0;
    for (int i = 0; i < NCH; i++) begin
      add = add + PC_W'(clamp_vec[i]);
    end
    work_sum  = {1'b0, work_reg} + (CNT_W + 1)'(add);
    work_next = work_sum[CNT_W] ? {CNT_W{1'b1}} : work_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_dl_reg     <= '0;
      vs_dl_reg     <= '0;
      v_dl_reg      <= '0;
      vs_prev_reg   <= 1'b0;
      work_reg      <= '0;
      clamp_cnt_reg <= '0;
    end else begin
      hs_dl_reg   <= {hs_dl_reg[1:0], i_hs};
      vs_dl_reg   <= {vs_dl_reg[1:0], i_vs};
      v_dl_reg    <= {v_dl_reg[1:0], in_valid};
      vs_prev_reg <= i_vs;
      // flags of the frame's last valid cycle land on the falling edge and are folded in here
      if (vs_prev_reg && !i_vs) begin
        clamp_cnt_reg <= work_next;
        work_reg      <= '0;
      end else begin
        work_reg <= work_next;
      end
    end
  end

  assign o_hs      = hs_dl_reg[2];
  assign o_vs      = vs_dl_reg[2];
  assign o_valid   = v_dl_reg[2];
  assign clamp_cnt = clamp_cnt_reg;

endmodule

// File: tb/tb_interpolator_mc.sv
// Self-checking bench for interpolator_mc: arithmetic reference model, directed and random stimulus.
module tb_interpolator_mc;
  import interp_pkg::*;

  localparam int NCH = 3, PIX_W = 10, LVL_W = 8, BND_W = 12, MAX_INTV = 16;
  localparam int BW = NCH * BND_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_hs = 1'b0, i_vs = 1'b0;
  logic [NCH*PIX_W-1:0]     pixel_in = '0;
  logic [NCH*LVL_W-1:0]     lowLevel = '0;
  logic [NCH*(LVL_W+1)-1:0] highLevel = '0;
  logic [BW-1:0]            lobound = '0, upbound = '0;
  logic o_hs, o_vs, o_valid, o_hs4, o_vs4, o_valid4;
  logic [BW-1:0] bound_out, bound_out4;
  logic [15:0]   clamp_cnt;
  logic [3:0]    clamp_cnt4;

  int errors = 0;
  int checks = 0;

  // reference state: output pipeline stages and frame counters
  bit            st_v[3], st_hs[3], st_vs[3];
  logic [BW-1:0] st_b[3];
  int            m_work, m_cnt, m_work4, m_cnt4;
  bit            m_vs_prev;

  always #5 clk = ~clk;

  interpolator_mc dut (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .pixel_in(pixel_in),
    .lowLevel(lowLevel), .highLevel(highLevel), .lobound(lobound), .upbound(upbound),
    .o_hs(o_hs), .o_vs(o_vs), .o_valid(o_valid), .bound_out(bound_out), .clamp_cnt(clamp_cnt)
  );

  interpolator_mc #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .pixel_in(pixel_in),
    .lowLevel(lowLevel), .highLevel(highLevel), .lobound(lobound), .upbound(upbound),
    .o_hs(o_hs4), .o_vs(o_vs4), .o_valid(o_valid4), .bound_out(bound_out4), .clamp_cnt(clamp_cnt4)
  );

  function automatic void ref_lane(input int p, input int l, input int h, input int lob,
                                   input int upb, output int bnd, output bit clamped);
    int diff, intv, alpha;
    longint prod;
    clamped = 1'b0;
    diff = upb - lob;
    if (diff < 0) begin diff = 0; clamped = 1'b1; end
    intv = h - l;
    if (intv < 1) begin intv = 1; clamped = 1'b1; end
    if (intv > MAX_INTV) begin intv = MAX_INTV; clamped = 1'b1; end
    alpha = p - 4 * l;
    if (alpha < 0) begin alpha = 0; clamped = 1'b1; end
    if (alpha > 4 * intv) begin alpha = 4 * intv; clamped = 1'b1; end
    prod = longint'(diff) * longint'(alpha) * longint'(65536 / intv);
`ifdef INTERP_ROUND_EN
    prod = prod + 131072;
`endif
    bnd = lob + int'(prod / 262144);
    if (bnd > BND_SAT) bnd = BND_SAT;
  endfunction

  task automatic set_lane(input int c, input int p, input int l, input int h,
                          input int lob, input int upb);
    pixel_in[c*PIX_W +: PIX_W]             = PIX_W'(p);
    lowLevel[c*LVL_W +: LVL_W]             = LVL_W'(l);
    highLevel[c*(LVL_W+1) +: (LVL_W+1)]    = (LVL_W+1)'(h);
    lobound[c*BND_W +: BND_W]              = BND_W'(lob);
    upbound[c*BND_W +: BND_W]              = BND_W'(upb);
  endtask

  task automatic set_random_lanes();
    for (int c = 0; c < NCH; c++) begin
      int l, h, p;
      l = int'($urandom_range(0, 255));
      h = l + int'($urandom_range(0, 22)) - 2;
      if (h < 0) h = 0;
      p = 4 * l + int'($urandom_range(0, 90)) - 8;
      if (p < 0) p = 0;
      if (p > 1023) p = 1023;
      set_lane(c, p, l, h, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    end
  endtask

  // advance one clock, update the model from the inputs seen at that edge, sample at +1
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        st_v[s] = 0; st_hs[s] = 0; st_vs[s] = 0; st_b[s] = '0;
      end
      m_work = 0; m_cnt = 0; m_work4 = 0; m_cnt4 = 0; m_vs_prev = 0;
    end else begin
      bit v;
      int n;
      logic [BW-1:0] eb;
      v = i_hs & i_vs;
      n = 0;
      eb = '0;
      for (int c = 0; c < NCH; c++) begin
        int bnd;
        bit cl;
        ref_lane(int'(pixel_in[c*PIX_W +: PIX_W]), int'(lowLevel[c*LVL_W +: LVL_W]),
                 int'(highLevel[c*(LVL_W+1) +: (LVL_W+1)]), int'(lobound[c*BND_W +: BND_W]),
                 int'(upbound[c*BND_W +: BND_W]), bnd, cl);
        if (v) begin
          eb[c*BND_W +: BND_W] = BND_W'(bnd);
          n += int'(cl);
        end
      end
      for (int s = 2; s > 0; s--) begin
        st_v[s] = st_v[s-1]; st_hs[s] = st_hs[s-1]; st_vs[s] = st_vs[s-1]; st_b[s] = st_b[s-1];
      end
      st_v[0] = v; st_hs[0] = i_hs; st_vs[0] = i_vs; st_b[0] = eb;
      m_work  = (m_work + n > 65535) ? 65535 : m_work + n;
      m_work4 = (m_work4 + n > 15) ? 15 : m_work4 + n;
      if (m_vs_prev && !i_vs) begin
        m_cnt = m_work; m_work = 0;
        m_cnt4 = m_work4; m_work4 = 0;
      end
      m_vs_prev = i_vs;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_hs = 1'b1; i_vs = 1'b1;
    set_random_lanes();
    tick();
    tick();
    checks++;
    if ({o_hs, o_vs, o_valid} !== 3'b000)
      $display("FAIL reset_syncs: got %b want 000", {o_hs, o_vs, o_valid});
    checks++;
    if (bound_out !== '0) $display("FAIL reset_bound: got %h want 0", bound_out);
    checks++;
    if (clamp_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", clamp_cnt);
    errors += int'({o_hs, o_vs, o_valid} !== 3'b000) + int'(bound_out !== '0)
            + int'(clamp_cnt !== 16'd0);
    rst_n = 1'b1;
    i_hs = 1'b0; i_vs = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int exp0[3], exp1[3];
`ifdef INTERP_ROUND_EN
    exp0 = '{12'h120, 12'h12B, 12'h100};
`else
    exp0 = '{12'h120, 12'h12A, 12'h100};
`endif
    exp1 = '{12'h200, 12'h120, 12'hFFF};
    i_hs = 1'b1; i_vs = 1'b1;
    set_lane(0, 408, 100, 104, 12'h100, 12'h140);
    set_lane(1, 408, 100, 103, 12'h100, 12'h140);
    set_lane(2, 390, 100, 104, 12'h100, 12'h140);
    tick();
    set_lane(0, 408, 100, 104, 12'h200, 12'h100);
    set_lane(1, 402, 100, 100, 12'h100, 12'h140);
    set_lane(2, 204, 50, 50, 12'hFF0, 12'hFFF);
    tick();
    i_hs = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_valid[%0d]: got %b want 1", k, o_valid);
      end
      for (int c = 0; c < NCH; c++) begin
        int want;
        want = (k == 0) ? exp0[c] : exp1[c];
        checks++;
        if (bound_out[c*BND_W +: BND_W] !== BND_W'(want)) begin
          errors++;
          $display("FAIL basic_bound[%0d] ch%0d: got %h want %h", k, c,
                   bound_out[c*BND_W +: BND_W], want);
        end
      end
      tick();
    end
    checks++;
    if (o_valid !== 1'b0 || bound_out !== '0) begin
      errors++;
      $display("FAIL basic_tail: valid %b bound %h want 0/0", o_valid, bound_out);
    end
  endtask

  task automatic test_clamp_count();
    i_hs = 1'b1; i_vs = 1'b0;
    tick();
    for (int f = 0; f < 2; f++) begin
      int want16, want4, ncyc;
      want16 = (f == 0) ? 15 : 20;
      want4  = 15;
      ncyc   = (f == 0) ? 6 : 7;
      i_vs = 1'b1;
      for (int k = 0; k < ncyc; k++) begin
        for (int c = 0; c < NCH; c++) set_lane(c, 390, 100, 104, 12'h100, 12'h140);
        // frame 0: one blanked cycle that must not count; frame 1: last cycle has 2 clamps
        i_hs = !(f == 0 && k == 2);
        if (f == 1 && k == ncyc - 1) set_lane(2, 408, 100, 104, 12'h100, 12'h140);
        tick();
      end
      i_hs = 1'b0; i_vs = 1'b0;
      tick();
      checks++;
      if (clamp_cnt !== 16'(want16) || clamp_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL clamp_cnt frame%0d: got %0d want %0d (model %0d)", f, clamp_cnt, want16, m_cnt);
      end
      checks++;
      if (clamp_cnt4 !== 4'(want4) || clamp_cnt4 !== 4'(m_cnt4)) begin
        errors++;
        $display("FAIL clamp_cnt_sat frame%0d: got %0d want %0d", f, clamp_cnt4, want4);
      end
      tick();
    end
  endtask

  task automatic test_drain();
    int hs_seen;
    hs_seen = 0;
    i_vs = 1'b1;
    for (int k = 0; k < 9; k++) begin
      i_hs = (k < 3);
      set_random_lanes();
      tick();
      hs_seen += int'(o_hs === 1'b1);
      checks++;
      if ({o_valid, o_hs, o_vs} !== {st_v[2], st_hs[2], st_vs[2]} || bound_out !== st_b[2]) begin
        errors++;
        $display("FAIL drain[%0d]: got v%b hs%b vs%b %h want v%b hs%b vs%b %h", k, o_valid, o_hs,
                 o_vs, bound_out, st_v[2], st_hs[2], st_vs[2], st_b[2]);
      end
    end
    checks++;
    if (hs_seen !== 3) begin
      errors++;
      $display("FAIL drain_hs_count: got %0d want 3", hs_seen);
    end
    checks++;
    if (o_valid !== 1'b0 || bound_out !== '0) begin
      errors++;
      $display("FAIL drain_tail: valid %b bound %h want 0/0", o_valid, bound_out);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      i_vs = (k % 60) < 52;
      i_hs = $urandom_range(0, 9) < 8;
      set_random_lanes();
      tick();
      checks++;
      if ({o_valid, o_hs, o_vs} !== {st_v[2], st_hs[2], st_vs[2]}) begin
        errors++;
        $display("FAIL rand_sync[%0d]: got %b want %b", k, {o_valid, o_hs, o_vs},
                 {st_v[2], st_hs[2], st_vs[2]});
      end
      checks++;
      if (bound_out !== st_b[2] || bound_out4 !== st_b[2]) begin
        errors++;
        $display("FAIL rand_bound[%0d]: got %h want %h", k, bound_out, st_b[2]);
      end
      checks++;
      if (clamp_cnt !== 16'(m_cnt) || clamp_cnt4 !== 4'(m_cnt4)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", k, clamp_cnt, clamp_cnt4,
                 m_cnt, m_cnt4);
      end
    end
  endtask

  task automatic test_reset_mid();
    i_hs = 1'b1; i_vs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_random_lanes();
      tick();
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({o_hs, o_vs, o_valid} !== 3'b000 || bound_out !== '0 || clamp_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_now: sync %b bound %h cnt %0d want all 0", {o_hs, o_vs, o_valid},
               bound_out, clamp_cnt);
    end
    rst_n = 1'b1;
    i_hs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0 || bound_out !== '0 || o_valid4 !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale[%0d]: valid %b bound %h want 0/0", k, o_valid, bound_out);
      end
    end
    checks++;
    if (o_vs !== st_vs[2] || o_vs4 !== st_vs[2] || o_hs4 !== st_hs[2]) begin
      errors++;
      $display("FAIL midreset_vs: got %b want %b", o_vs, st_vs[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp_count();
    test_drain();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interpolator_mc.md
Name: interpolator_mc

Overview:
- Multi-channel, parametrised successor of the single-lane 10-bit interpolator in the SPR datapath.
- Per subpixel channel it computes the full interpolated bound: out = lobound + (upbound-lobound)*alpha/interval.
- Fixed-latency pipeline with valid/sync alignment, input clamping and a per-frame clamp-event counter.
- Sits between the level-lookup stage and the subpixel filter.

Parameters:
- NCH, 3, number of independent channels.
- PIX_W, 10, pixel width; 2 fractional bits relative to level units.
- LVL_W, 8, lowLevel width; highLevel is LVL_W+1.
- BND_W, 12, bound width, Q8.4 unsigned.
- MAX_INTV, 16, largest legal interval.
- CNT_W, 16, clamp counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_hs  in  1  line active, high.
- i_vs  in  1  frame active, high.
- pixel_in  in  NCH*PIX_W  packed; channel 0 in the LSBs.
- lowLevel  in  NCH*LVL_W.
- highLevel  in  NCH*(LVL_W+1).
- lobound  in  NCH*BND_W.
- upbound  in  NCH*BND_W.
- o_hs  out  1  i_hs delayed 3 cycles.
- o_vs  out  1  i_vs delayed 3 cycles.
- o_valid  out  1  output data valid.
- bound_out  out  NCH*BND_W  interpolated bound, Q8.4.
- clamp_cnt  out  CNT_W  clamp events in the previous frame.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). Reset takes priority over everything else. All pipeline registers, o_hs, o_vs, o_valid, bound_out, clamp_cnt and the working counter reset to 0.
- Input valid is i_hs & i_vs, sampled every cycle. There is no backpressure.
- Latency is exactly 3 cycles. o_valid, o_hs and o_vs are the input valid and syncs delayed by 3 cycles.
- Blanking does not clear in-flight data. The pipeline keeps advancing, so the last pixels of a line still emerge. Invalid stages carry zero data, and bound_out = 0 whenever o_valid = 0.
- S1, per channel:
  - diff = upbound - lobound; if negative, diff = 0.
  - intv = highLevel - lowLevel; if < 1, intv = 1; if > MAX_INTV, intv = MAX_INTV.
  - alpha = pixel_in - (lowLevel<<2), clamped to [0, intv<<2].
  - Register diff, alpha, intv, lobound and a clamp flag (any of the clamps above fired).
- S2: delta = diff*alpha at full width (BND_W+PIX_W bits); recip = RECIP_LUT[intv]. Forward lobound.
- S3: q = (delta*recip) >> (RECIP_FRAC+2) at full width; out = lobound + q, saturated to 2^BND_W-1.
- Counter:
  - While input is valid, the working counter adds the number of channels whose clamp fired this cycle, saturating at 2^CNT_W-1.
  - On the cycle i_vs falls (i_vs=0, previous i_vs=1), clamp_cnt is loaded with the working counter and the working counter is cleared. This cycle has no valid input, so there is no collision.
- Reset mid-frame drops in-flight data. The first frame after reset reports the count accumulated since reset.

Optional Feature:
- INTERP_ROUND_EN defined: S3 adds 1<<(RECIP_FRAC+1) before the shift (round half up).
- INTERP_ROUND_EN undefined: the shift truncates.
- Latency and widths are identical in both cases.

Decomposition:
- Package interp_pkg holds:
  - default width constants;
  - RECIP_FRAC = 16 and RECIP_W = 17;
  - RECIP_LUT constant function, recip[n] = floor(65536/n) for n = 1..MAX_INTV, so recip[1] = 65536;
  - bound saturation constant.
- Sub-module interp_lane: one channel, stages S1–S3 and its clamp flag, instantiated NCH times.
- Top level holds the sync/valid delay line and the frame counter.

Test Plan:
- Basic interpolation: low=100, high=104, lobound=0x100, upbound=0x140, pixel=408, syncs high → 3 cycles later o_valid=1 and bound_out=0x120.
- Rounding: interval 3 (low=100, high=103), pixel=408, same bounds → 0x12A without INTERP_ROUND_EN, 0x12B with it.
- Clamps: pixel=390 < 400 → alpha 0, out=lobound. upbound<lobound → out=lobound. high=low → intv=1. Three channels each clamped for 5 valid cycles, then i_vs falls → clamp_cnt=15.
- Drain: i_hs drops right after 3 valid pixels → all 3 emerge with o_valid=1, o_hs high on exactly those cycles, then bound_out=0.
- Saturation: CNT_W=4 build with 20 clamp events → clamp_cnt=15. Bound overflow case → bound_out=0xFFF.
- Reset mid-line: rst_n=0 for 1 cycle with the pipeline full → all outputs 0 the next cycle, with no stale valid data afterwards.
